// File: rtl/p08_cfg_spi_sequencer.sv
// p08_cfg_spi_sequencer: round-robin SPI host feeding the rbzero vector and register ports.
module p08_cfg_spi_sequencer #(
  parameter int PAYLOAD_W = 80,
  parameter int LEN_W = 7,
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4,
  parameter bit VEC_VBLANK_ONLY = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_vblank,
  input  logic                 i_vec_req,
  input  logic [LEN_W-1:0]     i_vec_len,
  input  logic [PAYLOAD_W-1:0] i_vec_data,
  output logic                 o_vec_gnt,
  output logic                 o_vec_done,
  input  logic                 i_reg_req,
  input  logic [LEN_W-1:0]     i_reg_len,
  input  logic [PAYLOAD_W-1:0] i_reg_data,
  output logic                 o_reg_gnt,
  output logic                 o_reg_done,
  output logic                 o_err,
  output logic                 o_busy,
  output logic                 o_vec_csb,
  output logic                 o_vec_sclk,
  output logic                 o_vec_mosi,
  output logic                 o_reg_csb,
  output logic                 o_reg_sclk,
  output logic                 o_reg_mosi
);
  localparam int CW = $clog2((CLK_DIV > GAP_CYC ? CLK_DIV : GAP_CYC) + 1);
  localparam logic [LEN_W:0] PMAX = (LEN_W+1)'(PAYLOAD_W);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, ERR} state_t;
  state_t state, state_n;
  logic tgt, tgt_n, last_reg, last_reg_n, hi, hi_n;
  logic act, act_n, sclk, sclk_n, mosi, mosi_n;
  logic vec_gnt_n, reg_gnt_n, done_n, err_n;
  logic [LEN_W-1:0] idx, idx_n, req_len;
  logic [PAYLOAD_W-1:0] data, data_n, req_data;
  logic [CW-1:0] cnt, cnt_n;
  logic vec_win, reg_win, bad, div_end;
  assign vec_win = i_vec_req & (!VEC_VBLANK_ONLY | i_vblank) & (!i_reg_req | last_reg);
  assign reg_win = i_reg_req & !vec_win;
  assign req_len = vec_win ? i_vec_len : i_reg_len;
  assign req_data = vec_win ? i_vec_data : i_reg_data;
  assign bad = (req_len == '0) | ({1'b0, req_len} > PMAX);
  assign div_end = cnt == CW'(CLK_DIV - 1);
  // idx holds the bit on MOSI; it steps down at each rising-phase start so the last bit is idx==0
  always_comb begin
    state_n = state;
    tgt_n = tgt;
    last_reg_n = last_reg;
    hi_n = hi;
    idx_n = idx;
    data_n = data;
    cnt_n = cnt + 1'b1;
    act_n = act;
    sclk_n = sclk;
    mosi_n = mosi;
    vec_gnt_n = 1'b0;
    reg_gnt_n = 1'b0;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (vec_win | reg_win) begin
        tgt_n = reg_win;
        last_reg_n = reg_win;
        vec_gnt_n = vec_win;
        reg_gnt_n = reg_win;
        data_n = req_data;
        idx_n = req_len - 1'b1;
        cnt_n = '0;
        state_n = bad ? ERR : SETUP;
        act_n = !bad;
        mosi_n = bad ? 1'b0 : req_data[idx_n];
      end
      SETUP: if (div_end) begin
        state_n = SHIFT;
        cnt_n = '0;
        hi_n = 1'b1;
        sclk_n = 1'b1;
      end
      SHIFT: if (div_end) begin
        cnt_n = '0;
        if (hi) begin
          hi_n = 1'b0;
          sclk_n = 1'b0;
          mosi_n = (idx != '0) ? data[idx - 1'b1] : mosi;
        end else if (idx == '0) begin
          state_n = GAP;
          act_n = 1'b0;
          mosi_n = 1'b0;
          done_n = 1'b1;
        end else begin
          idx_n = idx - 1'b1;
          hi_n = 1'b1;
          sclk_n = 1'b1;
        end
      end
      GAP: state_n = (cnt == CW'(GAP_CYC - 1)) ? IDLE : GAP;
      ERR: begin
        state_n = IDLE;
        done_n = 1'b1;
        err_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      tgt <= 1'b0;
      last_reg <= 1'b1;
      hi <= 1'b0;
      idx <= '0;
      data <= '0;
      cnt <= '0;
      act <= 1'b0;
      sclk <= 1'b0;
      mosi <= 1'b0;
      o_vec_gnt <= 1'b0;
      o_reg_gnt <= 1'b0;
      o_vec_done <= 1'b0;
      o_reg_done <= 1'b0;
      o_err <= 1'b0;
      o_busy <= 1'b0;
      o_vec_csb <= 1'b1;
      o_vec_sclk <= 1'b0;
      o_vec_mosi <= 1'b0;
      o_reg_csb <= 1'b1;
      o_reg_sclk <= 1'b0;
      o_reg_mosi <= 1'b0;
    end else begin
      state <= state_n;
      tgt <= tgt_n;
      last_reg <= last_reg_n;
      hi <= hi_n;
      idx <= idx_n;
      data <= data_n;
      cnt <= cnt_n;
      act <= act_n;
      sclk <= sclk_n;
      mosi <= mosi_n;
      o_vec_gnt <= vec_gnt_n;
      o_reg_gnt <= reg_gnt_n;
      o_vec_done <= done_n & !tgt_n;
      o_reg_done <= done_n & tgt_n;
      o_err <= err_n;
      o_busy <= state_n != IDLE;
      o_vec_csb <= !(act_n & !tgt_n);
      o_vec_sclk <= sclk_n & !tgt_n;
      o_vec_mosi <= mosi_n & !tgt_n;
      o_reg_csb <= !(act_n & tgt_n);
      o_reg_sclk <= sclk_n & tgt_n;
      o_reg_mosi <= mosi_n & tgt_n;
    end
  end
endmodule

// File: tb/tb_p08_cfg_spi_sequencer.sv
// tb_p08_cfg_spi_sequencer: directed scenarios on a CLK_DIV=2 instance and a CLK_DIV=1 instance.
module tb_p08_cfg_spi_sequencer;
  localparam int PW = 80;
  localparam int LW = 7;
  logic clk = 1'b0, rst_n = 1'b0, vblank = 1'b0, vec_req = 1'b0, reg_req = 1'b0;
  logic [LW-1:0] vec_len = '0, reg_len = '0;
  logic [PW-1:0] vec_data = '0, reg_data = '0;
  logic vec_gnt, vec_done, reg_gnt, reg_done, err, busy;
  logic vec_csb, vec_sclk, vec_mosi, reg_csb, reg_sclk, reg_mosi;
  logic s_vec_gnt, s_vec_done, s_reg_gnt, s_reg_done, s_err, s_busy;
  logic s_vec_csb, s_vec_sclk, s_vec_mosi, s_reg_csb, s_reg_sclk, s_reg_mosi;
  int checks = 0, errors = 0;
  int w_low, w_edges, w_gcnt;
  logic [127:0] w_bits;
  bit w_ok, w_end_done, w_early_done, w_other;

  p08_cfg_spi_sequencer #(.CLK_DIV(2), .GAP_CYC(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_vblank(vblank),
    .i_vec_req(vec_req), .i_vec_len(vec_len), .i_vec_data(vec_data), .o_vec_gnt(vec_gnt), .o_vec_done(vec_done),
    .i_reg_req(reg_req), .i_reg_len(reg_len), .i_reg_data(reg_data), .o_reg_gnt(reg_gnt), .o_reg_done(reg_done),
    .o_err(err), .o_busy(busy),
    .o_vec_csb(vec_csb), .o_vec_sclk(vec_sclk), .o_vec_mosi(vec_mosi),
    .o_reg_csb(reg_csb), .o_reg_sclk(reg_sclk), .o_reg_mosi(reg_mosi));

  p08_cfg_spi_sequencer #(.CLK_DIV(1), .GAP_CYC(4)) dut_slow (
    .i_clk(clk), .i_reset_n(rst_n), .i_vblank(vblank),
    .i_vec_req(vec_req), .i_vec_len(vec_len), .i_vec_data(vec_data), .o_vec_gnt(s_vec_gnt), .o_vec_done(s_vec_done),
    .i_reg_req(reg_req), .i_reg_len(reg_len), .i_reg_data(reg_data), .o_reg_gnt(s_reg_gnt), .o_reg_done(s_reg_done),
    .o_err(s_err), .o_busy(s_busy),
    .o_vec_csb(s_vec_csb), .o_vec_sclk(s_vec_sclk), .o_vec_mosi(s_vec_mosi),
    .o_reg_csb(s_reg_csb), .o_reg_sclk(s_reg_sclk), .o_reg_mosi(s_reg_mosi));

  always #5 clk = ~clk;

  // port select: 0 = vec, 1 = reg, 2 = reg of the CLK_DIV=1 instance
  task automatic wait_gnt(input int w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (w == 0 ? vec_gnt : w == 1 ? reg_gnt : s_reg_gnt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // records one CSB-low window starting at the current sample
  task automatic watch(input int w);
    logic c, s, m, d, g, oi, prev;
    bit started;
    w_low = 0; w_edges = 0; w_bits = '0; w_gcnt = 0;
    w_ok = 1'b0; w_end_done = 1'b0; w_early_done = 1'b0; w_other = 1'b0;
    prev = 1'b0; started = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      c = w == 0 ? vec_csb : w == 1 ? reg_csb : s_reg_csb;
      s = w == 0 ? vec_sclk : w == 1 ? reg_sclk : s_reg_sclk;
      m = w == 0 ? vec_mosi : w == 1 ? reg_mosi : s_reg_mosi;
      d = w == 0 ? vec_done : w == 1 ? reg_done : s_reg_done;
      g = w == 0 ? vec_gnt : w == 1 ? reg_gnt : s_reg_gnt;
      oi = w == 0 ? (!reg_csb || reg_sclk || reg_mosi) :
           w == 1 ? (!vec_csb || vec_sclk || vec_mosi) : (!s_vec_csb || s_vec_sclk || s_vec_mosi);
      if (g) w_gcnt++;
      if (oi) w_other = 1'b1;
      if (c && started) begin
        w_end_done = d;
        w_ok = 1'b1;
        break;
      end
      if (!c) begin
        started = 1'b1;
        w_low++;
        if (d) w_early_done = 1'b1;
        if (s && !prev) begin
          w_edges++;
          w_bits = {w_bits[126:0], m};
        end
      end
      prev = s;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 1000 && (busy || s_busy); i++) @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || s_busy !== 1'b0) begin errors++; $display("FAIL %s_idle: busy=%b/%b want 0/0", tag, busy, s_busy); end
  endtask

  task automatic test_reset();
    logic [11:0] o, so;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    o = {vec_csb, reg_csb, vec_sclk, reg_sclk, vec_mosi, reg_mosi, vec_gnt, reg_gnt, vec_done, reg_done, err, busy};
    so = {s_vec_csb, s_reg_csb, s_vec_sclk, s_reg_sclk, s_vec_mosi, s_reg_mosi, s_vec_gnt, s_reg_gnt, s_vec_done, s_reg_done, s_err, s_busy};
    checks++; if (o !== 12'b1100_0000_0000) begin errors++; $display("FAIL reset_outs: got %b want 110000000000", o); end
    checks++; if (so !== 12'b1100_0000_0000) begin errors++; $display("FAIL reset_outs_slow: got %b want 110000000000", so); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, vec_csb, reg_csb} !== 3'b011) begin errors++; $display("FAIL reset_idle: got %b want 011", {busy, vec_csb, reg_csb}); end
  endtask

  task automatic test_single_reg();
    bit ok;
    reg_len = 7'd8; reg_data = 80'hA5; reg_req = 1'b1;
    wait_gnt(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_gnt: got none want reg_gnt"); end
    reg_req = 1'b0;
    watch(1);
    checks++; if (!w_ok) begin errors++; $display("FAIL t1_end: csb never rose"); end
    checks++; if (w_low !== 34) begin errors++; $display("FAIL t1_csb_low: got %0d want 34", w_low); end
    checks++; if (w_edges !== 8) begin errors++; $display("FAIL t1_edges: got %0d want 8", w_edges); end
    checks++; if (w_bits[7:0] !== 8'hA5) begin errors++; $display("FAIL t1_bits: got %h want a5", w_bits[7:0]); end
    checks++; if ({w_end_done, w_early_done} !== 2'b10) begin errors++; $display("FAIL t1_done: got end=%b early=%b want 1/0", w_end_done, w_early_done); end
    checks++; if (w_other !== 1'b0) begin errors++; $display("FAIL t1_vec_idle: got activity want idle"); end
    checks++; if (w_gcnt !== 1) begin errors++; $display("FAIL t1_gnt_pulse: got %0d want 1", w_gcnt); end
    wait_idle("t1");
  endtask

  task automatic test_back_to_back();
    int n, hi_run, min_gap;
    bit started;
    int seq [4];
    vblank = 1'b1;
    vec_len = 7'd72; vec_data = {8'h00, 72'h5A_F00F_1234_8765_ABCD};
    reg_len = 7'd16; reg_data = 80'h3C96;
    vec_req = 1'b1; reg_req = 1'b1;
    n = 0; hi_run = 0; min_gap = 1000; started = 1'b0;
    for (int i = 0; i < 3000 && n < 4; i++) begin
      @(negedge clk);
      if (vec_csb && reg_csb) hi_run++;
      else begin
        if (started && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
        hi_run = 0;
        started = 1'b1;
      end
      if (vec_gnt && n < 4) begin seq[n] = 0; n++; end
      if (reg_gnt && n < 4) begin seq[n] = 1; n++; end
    end
    vec_req = 1'b0; reg_req = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL t2_grants: got %0d want 4", n); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (seq[k] !== k % 2) begin errors++; $display("FAIL t2_order%0d: got %0d want %0d", k, seq[k], k % 2); end
    end
    checks++; if (min_gap < 4) begin errors++; $display("FAIL t2_gap: got %0d want >=4", min_gap); end
    wait_idle("t2");
  endtask

  task automatic test_vblank_gating();
    int g;
    vblank = 1'b0;
    vec_len = 7'd72; vec_data = {8'hFF, 72'hC3_0123_4567_89AB_CDEF};
    vec_req = 1'b1;
    g = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (vec_gnt) g++;
    end
    checks++; if (g !== 0) begin errors++; $display("FAIL t3_blocked: got %0d gnts want 0", g); end
    vblank = 1'b1;
    @(negedge clk);
    checks++; if (vec_gnt !== 1'b1) begin errors++; $display("FAIL t3_gnt_latency: got %b want 1", vec_gnt); end
    vec_req = 1'b0;
    fork
      watch(0);
      begin
        repeat (60) @(negedge clk);
        vblank = 1'b0;
      end
    join
    checks++; if (w_low !== 290) begin errors++; $display("FAIL t3_csb_low: got %0d want 290", w_low); end
    checks++; if (w_edges !== 72) begin errors++; $display("FAIL t3_edges: got %0d want 72", w_edges); end
    checks++; if (w_bits[71:0] !== 72'hC3_0123_4567_89AB_CDEF) begin errors++; $display("FAIL t3_bits: got %h want c30123456789abcdef", w_bits[71:0]); end
    checks++; if (w_end_done !== 1'b1) begin errors++; $display("FAIL t3_done: got %b want 1", w_end_done); end
    wait_idle("t3");
  endtask

  task automatic test_illegal_len();
    bit ok;
    reg_len = 7'd0; reg_data = 80'hFF; reg_req = 1'b1;
    wait_gnt(1, ok);
    checks++; if (!ok || reg_csb !== 1'b1) begin errors++; $display("FAIL t4a_gnt: got gnt=%b csb=%b want 1/1", ok, reg_csb); end
    reg_req = 1'b0;
    @(negedge clk);
    checks++; if ({err, reg_done, reg_csb} !== 3'b111) begin errors++; $display("FAIL t4a_err: got %b want 111", {err, reg_done, reg_csb}); end
    @(negedge clk);
    checks++; if ({busy, err, reg_csb} !== 3'b001) begin errors++; $display("FAIL t4a_after: got %b want 001", {busy, err, reg_csb}); end
    vblank = 1'b1;
    vec_len = 7'd81; vec_data = 80'h1; vec_req = 1'b1;
    wait_gnt(0, ok);
    checks++; if (!ok || vec_csb !== 1'b1) begin errors++; $display("FAIL t4b_gnt: got gnt=%b csb=%b want 1/1", ok, vec_csb); end
    vec_req = 1'b0;
    @(negedge clk);
    checks++; if ({err, vec_done, vec_csb, reg_done} !== 4'b1110) begin errors++; $display("FAIL t4b_err: got %b want 1110", {err, vec_done, vec_csb, reg_done}); end
    @(negedge clk);
    checks++; if ({busy, err, vec_csb} !== 3'b001) begin errors++; $display("FAIL t4b_after: got %b want 001", {busy, err, vec_csb}); end
    wait_idle("t4");
  endtask

  task automatic test_reset_mid();
    bit ok, dn;
    int e;
    logic prev;
    reg_len = 7'd32; reg_data = 80'hDEADBEEF; reg_req = 1'b1;
    wait_gnt(1, ok);
    reg_req = 1'b0;
    e = 0; prev = 1'b0;
    for (int i = 0; i < 500 && e < 10; i++) begin
      @(negedge clk);
      if (reg_sclk && !prev) e++;
      prev = reg_sclk;
    end
    checks++; if (!ok || e !== 10) begin errors++; $display("FAIL t5_edges: got gnt=%b edges=%0d want 1/10", ok, e); end
    rst_n = 1'b0;
    #1;
    checks++; if ({reg_csb, reg_sclk, reg_mosi, busy} !== 4'b1000) begin errors++; $display("FAIL t5_abort: got %b want 1000", {reg_csb, reg_sclk, reg_mosi, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (reg_done || busy) dn = 1'b1;
    end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL t5_no_done: got activity want none"); end
    reg_len = 7'd4; reg_data = 80'h9; reg_req = 1'b1;
    wait_gnt(1, ok);
    reg_req = 1'b0;
    watch(1);
    checks++; if (!ok || w_edges !== 4 || w_bits[3:0] !== 4'h9) begin errors++; $display("FAIL t5_resend: got gnt=%b edges=%0d bits=%h want 1/4/9", ok, w_edges, w_bits[3:0]); end
    checks++; if (w_low !== 18) begin errors++; $display("FAIL t5_csb_low: got %0d want 18", w_low); end
    wait_idle("t5");
  endtask

  task automatic test_slow_max();
    bit ok;
    reg_len = 7'd80; reg_data = {20{4'hA}}; reg_req = 1'b1;
    wait_gnt(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t6_gnt: got none want gnt"); end
    reg_req = 1'b0;
    watch(2);
    checks++; if (w_low !== 161) begin errors++; $display("FAIL t6_csb_low: got %0d want 161", w_low); end
    checks++; if (w_edges !== 80) begin errors++; $display("FAIL t6_edges: got %0d want 80", w_edges); end
    checks++; if (w_bits[79:0] !== {20{4'hA}}) begin errors++; $display("FAIL t6_bits: got %h want aaaa...", w_bits[79:0]); end
    checks++; if (w_end_done !== 1'b1) begin errors++; $display("FAIL t6_done: got %b want 1", w_end_done); end
    wait_idle("t6");
  endtask

  initial begin
    test_reset();
    test_single_reg();
    test_back_to_back();
    test_vblank_gating();
    test_illegal_len();
    test_reset_mid();
    test_slow_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
